param_seq_gen: RTL and testbench

Parametrised successor to the fixed 4-bit q_out/valid sequence generator used in top.
- Generates a WIDTH-bit sequence in one of four modes: binary up, binary down, Gray, one-hot ring.
- Runs to a programmable terminal index, either once (one-shot) or continuously (wrapping).
- Adds start/stop/enable control, a done strobe and a busy flag, and sits where the 4-bit generator sat.

---
 rtl/param_seq_gen_pkg.sv | 19 +
 rtl/param_seq_gen_seq_encode.sv | 33 +++
 rtl/param_seq_gen.sv | 185 ++++++++++++++++++
 tb/tb_param_seq_gen.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/param_seq_gen_pkg.sv
// ---------------------------------------------------------------------------
// param_seq_pkg
//   Shared definitions for the parametrised sequence generator:
//   sequence mode codes and the controller state encoding.
// ---------------------------------------------------------------------------
package param_seq_pkg;

   localparam logic [1:0] MODE_UP   = 2'd0;
   localparam logic [1:0] MODE_DOWN = 2'd1;
   localparam logic [1:0] MODE_GRAY = 2'd2;
   localparam logic [1:0] MODE_RING = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage : param_seq_pkg

// File: rtl/param_seq_gen_seq_encode.sv
// ---------------------------------------------------------------------------
// seq_encode
//   Combinational mapping from a sequence index to the presented value.
//   Ports:
//     i_idx   : sequence index
//     i_term  : terminal index (reference for the down-count mode)
//     i_ring  : one-hot ring value (used directly in ring mode)
//     i_mode  : sequence mode
//     o_value : encoded value
// ---------------------------------------------------------------------------
module seq_encode
   import param_seq_pkg::*;
#(
   parameter int unsigned WIDTH = 4
) (
   input  logic [WIDTH-1:0] i_idx,
   input  logic [WIDTH-1:0] i_term,
   input  logic [WIDTH-1:0] i_ring,
   input  logic [1:0]       i_mode,
   output logic [WIDTH-1:0] o_value
);

   always_comb begin
      o_value = '0;
      case (i_mode)
         MODE_UP:   o_value = i_idx;
         MODE_DOWN: o_value = i_term - i_idx;
         MODE_GRAY: o_value = i_idx ^ (i_idx >> 1);
         default:   o_value = i_ring;
      endcase
   end

endmodule : seq_encode

// File: rtl/param_seq_gen.sv
// ---------------------------------------------------------------------------
// param_seq_gen
//   WIDTH-bit sequence generator (binary up/down, Gray, one-hot ring) that
//   runs to a programmable terminal index, once or continuously.
//   Ports:
//     clk      : system clock, rising edge
//     reset    : asynchronous active-low reset
//     en       : advance enable while running
//     start    : arm and start a run (honoured in IDLE/DONE only)
//     stop     : abort a run, return to IDLE (priority over start)
//     mode     : sequence mode, latched at start
//     term     : terminal index (length term+1), latched at start
//     one_shot : 1 = single pass, 0 = wrap, latched at start
//     q_out    : current sequence value
//     valid    : one-cycle strobe per newly presented value
//     done     : one-cycle pulse on completing a pass
//     busy     : high while running
// ---------------------------------------------------------------------------
module param_seq_gen
   import param_seq_pkg::*;
#(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             start,
   input  logic             stop,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] term,
   input  logic             one_shot,
   output logic [WIDTH-1:0] q_out,
   output logic             valid,
   output logic             done,
   output logic             busy
);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_idx;
   logic [WIDTH-1:0] r_ring;
   logic [WIDTH-1:0] r_term;
   logic [1:0]       r_mode;
   logic             r_os;

   logic [WIDTH-1:0] w_idx_nxt;
   logic [WIDTH-1:0] w_ring_nxt;
   logic [WIDTH-1:0] w_q_nxt;
   logic             w_valid_nxt;
   logic             w_done_nxt;
   logic             w_busy_nxt;
   logic             w_latch;

   logic             w_at_term;
   logic [WIDTH-1:0] w_enc_idx;
   logic [WIDTH-1:0] w_enc_ring;
   logic [WIDTH-1:0] w_enc_term;
   logic [1:0]       w_enc_mode;
   logic [WIDTH-1:0] w_enc_value;

   assign w_at_term = (r_idx == r_term);

   // One encoder serves start, wrap and advance: its inputs are the values
   // idx/ring will hold after this edge. Outside RUN the live mode/term
   // ports are used because they are being latched on the same edge.
   always_comb begin
      w_enc_idx  = '0;
      w_enc_ring = WIDTH'(1);
      w_enc_term = r_term;
      w_enc_mode = r_mode;
      if (r_state != ST_RUN) begin
         w_enc_term = term;
         w_enc_mode = mode;
      end else if (!w_at_term) begin
         w_enc_idx  = r_idx + WIDTH'(1);
         w_enc_ring = {r_ring[WIDTH-2:0], r_ring[WIDTH-1]};
      end
   end

   seq_encode #(
      .WIDTH (WIDTH)
   ) u_seq_encode (
      .i_idx   (w_enc_idx),
      .i_term  (w_enc_term),
      .i_ring  (w_enc_ring),
      .i_mode  (w_enc_mode),
      .o_value (w_enc_value)
   );

   // State and data registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= ST_IDLE;
         r_idx   <= '0;
         r_ring  <= '0;
         r_term  <= '0;
         r_mode  <= '0;
         r_os    <= 1'b0;
         q_out   <= '0;
         valid   <= 1'b0;
         done    <= 1'b0;
         busy    <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
         r_ring  <= w_ring_nxt;
         q_out   <= w_q_nxt;
         valid   <= w_valid_nxt;
         done    <= w_done_nxt;
         busy    <= w_busy_nxt;
         if (w_latch) begin
            r_term <= term;
            r_mode <= mode;
            r_os   <= one_shot;
         end
      end
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_RUN: begin
            if (stop)
               w_state_nxt = ST_IDLE;
            else if (en && w_at_term && r_os)
               w_state_nxt = ST_DONE;
         end
         default: begin
            if (stop)
               w_state_nxt = ST_IDLE;
            else if (start)
               w_state_nxt = ST_RUN;
         end
      endcase
   end

   // Output / datapath next values
   always_comb begin
      w_idx_nxt   = r_idx;
      w_ring_nxt  = r_ring;
      w_q_nxt     = q_out;
      w_valid_nxt = 1'b0;
      w_done_nxt  = 1'b0;
      w_busy_nxt  = busy;
      w_latch     = 1'b0;
      case (r_state)
         ST_RUN: begin
            if (stop) begin
               w_busy_nxt = 1'b0;
            end else if (en) begin
               if (w_at_term) begin
                  w_done_nxt = 1'b1;
                  if (r_os) begin
                     w_busy_nxt = 1'b0;
                  end else begin
                     w_idx_nxt   = '0;
                     w_ring_nxt  = WIDTH'(1);
                     w_q_nxt     = w_enc_value;
                     w_valid_nxt = 1'b1;
                  end
               end else begin
                  w_idx_nxt   = w_enc_idx;
                  w_ring_nxt  = w_enc_ring;
                  w_q_nxt     = w_enc_value;
                  w_valid_nxt = 1'b1;
               end
            end
         end
         default: begin
            if (stop) begin
               w_busy_nxt = 1'b0;
            end else if (start) begin
               w_latch     = 1'b1;
               w_idx_nxt   = '0;
               w_ring_nxt  = WIDTH'(1);
               w_q_nxt     = w_enc_value;
               w_valid_nxt = 1'b1;
               w_busy_nxt  = 1'b1;
            end
         end
      endcase
   end

endmodule : param_seq_gen

// File: tb/tb_param_seq_gen.sv
module tb_param_seq_gen;

   localparam int W = 4;

   logic         clk;
   logic         reset;
   logic         en;
   logic         start;
   logic         stop;
   logic [1:0]   mode;
   logic [W-1:0] term;
   logic         one_shot;
   logic [W-1:0] q_out;
   logic         valid;
   logic         done;
   logic         busy;

   int n_vec;
   int n_err;

   // Reference model: the whole pass is precomputed as a list of values,
   // then the run simply walks a position through that list.
   int m_seq[$];
   int m_pos;
   bit m_run;
   bit m_os;
   int m_q;
   bit m_valid;
   bit m_done;
   bit m_busy;

   param_seq_gen #(.WIDTH(W)) dut (
      .clk      (clk),
      .reset    (reset),
      .en       (en),
      .start    (start),
      .stop     (stop),
      .mode     (mode),
      .term     (term),
      .one_shot (one_shot),
      .q_out    (q_out),
      .valid    (valid),
      .done     (done),
      .busy     (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input int obs, input int exp);
      n_vec++;
      if (obs != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic int ref_value(int md, int t, int k);
      int mask;
      mask = (1 << W) - 1;
      case (md)
         0:       return k;
         1:       return (t - k) & mask;
         2:       return k ^ (k >> 1);
         default: return (1 << (k % W)) & mask;
      endcase
   endfunction

   function automatic void model_reset();
      m_run = 0; m_os = 0; m_pos = 0;
      m_q = 0; m_valid = 0; m_done = 0; m_busy = 0;
   endfunction

   function automatic void model_step(bit s, bit p, bit e, int md, int t, bit o);
      m_valid = 0;
      m_done  = 0;
      if (!m_run) begin
         if (!p && s) begin
            m_seq.delete();
            for (int k = 0; k <= t; k++) m_seq.push_back(ref_value(md, t, k));
            m_pos = 0; m_q = m_seq[0]; m_valid = 1; m_busy = 1;
            m_run = 1; m_os = o;
         end
      end else if (p) begin
         m_run = 0; m_busy = 0;
      end else if (e) begin
         if (m_pos == m_seq.size() - 1) begin
            m_done = 1;
            if (m_os) begin
               m_run = 0; m_busy = 0;
            end else begin
               m_pos = 0; m_q = m_seq[0]; m_valid = 1;
            end
         end else begin
            m_pos++; m_q = m_seq[m_pos]; m_valid = 1;
         end
      end
   endfunction

   task automatic check_outputs();
      check_eq("q_out", int'(q_out), m_q);
      check_eq("valid", int'(valid), int'(m_valid));
      check_eq("done",  int'(done),  int'(m_done));
      check_eq("busy",  int'(busy),  int'(m_busy));
   endtask

   task automatic tick(input bit s, input bit p, input bit e,
                       input int md, input int t, input bit o);
      @(negedge clk);
      start = s; stop = p; en = e;
      mode = 2'(md); term = W'(t); one_shot = o;
      @(posedge clk);
      #1;
      model_step(s, p, e, md, t, o);
      check_outputs();
   endtask

   // Start a run and let it go for n further enabled cycles
   task automatic run_seq(input int md, input int t, input bit o, input int n);
      tick(1, 0, 1, md, t, o);
      for (int i = 0; i < n; i++) tick(0, 0, 1, md, t, o);
   endtask

   initial begin
      n_vec = 0; n_err = 0;
      model_reset();
      reset = 1'b0; en = 0; start = 0; stop = 0;
      mode = '0; term = '0; one_shot = 0;
      repeat (3) @(posedge clk);
      #1;
      check_outputs();
      @(negedge clk);
      reset = 1'b1;

      // Directed passes
      run_seq(0, 5, 1, 8);           // 0..5 then done, hold 5
      run_seq(2, 7, 0, 18);          // Gray, continuous
      tick(0, 1, 0, 0, 0, 0);        // stop
      run_seq(1, 9, 1, 11);          // down 9..0 then done
      run_seq(3, 5, 1, 7);           // ring 1,2,4,8,1,2 then done
      run_seq(0, 0, 0, 4);           // term=0 continuous
      tick(0, 1, 0, 0, 0, 0);
      run_seq(0, 0, 1, 3);           // term=0 one-shot
      run_seq(0, 15, 0, 20);         // full range wrap
      tick(0, 1, 0, 0, 0, 0);

      // en gap at q_out=3, start ignored in RUN, stop at 6
      run_seq(0, 9, 1, 3);
      tick(0, 0, 0, 0, 9, 1);
      tick(0, 0, 0, 0, 9, 1);
      tick(0, 0, 1, 0, 9, 1);
      tick(1, 0, 1, 2, 3, 0);        // start during RUN, different settings
      tick(0, 0, 1, 0, 9, 1);
      tick(0, 1, 1, 0, 9, 1);
      tick(0, 0, 1, 0, 9, 1);
      tick(1, 1, 1, 0, 9, 1);        // start+stop in IDLE
      tick(0, 0, 1, 0, 9, 1);

      // Asynchronous reset mid-run at q_out=5
      run_seq(0, 9, 1, 5);
      #2;
      start = 0; stop = 0;
      reset = 1'b0;
      #1;
      model_reset();
      check_eq("async_q",     int'(q_out), 0);
      check_eq("async_valid", int'(valid), 0);
      check_eq("async_busy",  int'(busy),  0);
      @(negedge clk);
      reset = 1'b1;
      run_seq(0, 9, 1, 3);

      // Randomized traffic
      for (int i = 0; i < 600; i++) begin
         bit s, p, e, o;
         int md, t;
         s  = ($urandom_range(0, 9) == 0);
         p  = ($urandom_range(0, 24) == 0);
         e  = ($urandom_range(0, 3) != 0);
         o  = $urandom_range(0, 1) != 0;
         md = $urandom_range(0, 3);
         t  = $urandom_range(0, (1 << W) - 1);
         tick(s, p, e, md, t, o);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   // Absolute bound on simulation time
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete, expected finish");
      $fatal(1);
   end

endmodule : tb_param_seq_gen
